// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: handshake bundle for the registered immediate generator.
//   Upstream side : in_valid, in_ready, inscode, in_pc
//   Downstream side: out_valid, out_ready, Immout, out_fmt, out_illegal, out_pc
// The slave modport is the generator; the master modport is the
// fetch/register-read environment around it.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inscode;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] Immout;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [XLEN-1:0] out_pc;

  modport master (
    output in_valid, inscode, in_pc, out_ready,
    input  in_ready, out_valid, Immout, out_fmt, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, inscode, in_pc, out_ready,
    output in_ready, out_valid, Immout, out_fmt, out_illegal, out_pc
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with valid/ready handshake.
// Decodes the RV32I format from inscode[6:0], builds the sign-extended
// immediate, flags unknown opcodes and carries the PC alongside. One output
// register plus a one-entry skid buffer absorb back-pressure without loss.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   bus         imm_gen_pipe_if.slave (input and output handshakes)
//   cnt_clr     synchronous clear of illegal_cnt (wins over increment)
//   illegal_cnt saturating count of accepted illegal instructions
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  imm_gen_pipe_if.slave      bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Decoded view of the current input word
  logic signed [31:0] imm32_s;
  logic [XLEN-1:0]    imm_s;
  logic [2:0]         fmt_s;
  logic               illegal_s;

  // Handshake
  logic in_ready_s;
  logic accept_s;

  // Output register
  logic            out_valid_r;
  logic [XLEN-1:0] out_imm_r;
  logic [2:0]      out_fmt_r;
  logic            out_ill_r;
  logic [XLEN-1:0] out_pc_r;

  // Skid entry
  logic            skid_valid_r;
  logic [XLEN-1:0] skid_imm_r;
  logic [2:0]      skid_fmt_r;
  logic            skid_ill_r;
  logic [XLEN-1:0] skid_pc_r;

  logic [CNT_W-1:0] cnt_r;

  // Opcode decode and 32-bit sign-extended immediate assembly
  always_comb begin
    imm32_s   = 32'sd0;
    fmt_s     = FMT_NONE;
    illegal_s = 1'b1;
    case (bus.inscode[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
        imm32_s   = {{20{bus.inscode[31]}}, bus.inscode[31:20]};
        fmt_s     = FMT_I;
        illegal_s = 1'b0;
      end
      7'b0100011: begin
        imm32_s   = {{20{bus.inscode[31]}}, bus.inscode[31:25], bus.inscode[11:7]};
        fmt_s     = FMT_S;
        illegal_s = 1'b0;
      end
      7'b1100011: begin
        imm32_s   = {{20{bus.inscode[31]}}, bus.inscode[7], bus.inscode[30:25],
                     bus.inscode[11:8], 1'b0};
        fmt_s     = FMT_B;
        illegal_s = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        imm32_s   = {bus.inscode[31:12], 12'b0};
        fmt_s     = FMT_U;
        illegal_s = 1'b0;
      end
      7'b1101111: begin
        imm32_s   = {{12{bus.inscode[31]}}, bus.inscode[19:12], bus.inscode[20],
                     bus.inscode[30:21], 1'b0};
        fmt_s     = FMT_J;
        illegal_s = 1'b0;
      end
      7'b0110011: begin
        imm32_s   = 32'sd0;
        fmt_s     = FMT_R;
        illegal_s = 1'b0;
      end
      default: begin
        imm32_s   = 32'sd0;
        fmt_s     = FMT_NONE;
        illegal_s = 1'b1;
      end
    endcase
  end

  // Every RV32I immediate already has inscode[31] as its top bit, so a signed
  // widening cast gives the XLEN=64 sign extension (including U-type).
  assign imm_s = XLEN'(imm32_s);

  // Ready is forced low during reset so nothing is accepted then.
  assign in_ready_s = ~skid_valid_r & ~rst;
  assign accept_s   = bus.in_valid & in_ready_s;

  // Output register and skid entry. A skid drain and a new accept are
  // mutually exclusive because in_ready is low while the skid is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_imm_r    <= '0;
      out_fmt_r    <= FMT_NONE;
      out_ill_r    <= 1'b0;
      out_pc_r     <= '0;
      skid_valid_r <= 1'b0;
      skid_imm_r   <= '0;
      skid_fmt_r   <= FMT_NONE;
      skid_ill_r   <= 1'b0;
      skid_pc_r    <= '0;
    end else begin
      if (!out_valid_r || bus.out_ready) begin
        if (skid_valid_r) begin
          out_valid_r  <= 1'b1;
          out_imm_r    <= skid_imm_r;
          out_fmt_r    <= skid_fmt_r;
          out_ill_r    <= skid_ill_r;
          out_pc_r     <= skid_pc_r;
          skid_valid_r <= 1'b0;
        end else if (accept_s) begin
          out_valid_r <= 1'b1;
          out_imm_r   <= imm_s;
          out_fmt_r   <= fmt_s;
          out_ill_r   <= illegal_s;
          out_pc_r    <= bus.in_pc;
        end else begin
          out_valid_r <= 1'b0;
        end
      end else if (accept_s) begin
        // Output is stalled: park the new entry in the skid.
        skid_valid_r <= 1'b1;
        skid_imm_r   <= imm_s;
        skid_fmt_r   <= fmt_s;
        skid_ill_r   <= illegal_s;
        skid_pc_r    <= bus.in_pc;
      end else begin
        skid_valid_r <= skid_valid_r;
      end
    end
  end

  // Saturating illegal-opcode counter; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (cnt_clr) begin
      cnt_r <= '0;
    end else if (accept_s && illegal_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.Immout      = out_imm_r;
  assign bus.out_fmt     = out_fmt_r;
  assign bus.out_illegal = out_ill_r;
  assign bus.out_pc      = out_pc_r;
  assign illegal_cnt     = cnt_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench with scoreboard queues for an XLEN=32
// (CNT_W=2) and an XLEN=64 instance of imm_gen_pipe sharing clock and reset.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr32;
  logic        clr64;
  logic [1:0]  cnt32;
  logic [15:0] cnt64;

  int errors = 0;
  int checks = 0;

  exp_t q32[$];
  exp_t q64[$];
  exp_t pend32;
  exp_t pend64;

  logic [1:0] cnt_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

  imm_gen_pipe_if #(.XLEN(32)) if32 ();
  imm_gen_pipe_if #(.XLEN(64)) if64 ();

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut32 (
    .clk(clk), .rst(rst), .bus(if32), .cnt_clr(clr32), .illegal_cnt(cnt32)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst(rst), .bus(if64), .cnt_clr(clr64), .illegal_cnt(cnt64)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive32(input logic [31:0] code, input logic [31:0] pc,
                         input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    if32.in_valid = 1'b1;
    if32.inscode  = code;
    if32.in_pc    = pc;
    pend32 = '{imm, fmt, ill, {32'b0, pc}};
  endtask

  task automatic drive64(input logic [31:0] code, input logic [63:0] pc,
                         input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    if64.in_valid = 1'b1;
    if64.inscode  = code;
    if64.in_pc    = pc;
    pend64 = '{imm, fmt, ill, pc};
  endtask

  // Sample handshakes mid-cycle: pop/compare leaving outputs, push accepted inputs.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (if32.out_valid && if32.out_ready) begin
      chk("q32_nonempty", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        chk("imm32", {32'b0, if32.Immout}, {32'b0, e.imm[31:0]});
        chk("fmt32", 64'(if32.out_fmt), 64'(e.fmt));
        chk("ill32", 64'(if32.out_illegal), 64'(e.ill));
        chk("pc32",  {32'b0, if32.out_pc}, e.pc);
      end
    end
    if (if64.out_valid && if64.out_ready) begin
      chk("q64_nonempty", 64'(q64.size() != 0), 64'd1);
      if (q64.size() != 0) begin
        e = q64.pop_front();
        chk("imm64", if64.Immout, e.imm);
        chk("fmt64", 64'(if64.out_fmt), 64'(e.fmt));
        chk("ill64", 64'(if64.out_illegal), 64'(e.ill));
        chk("pc64",  if64.out_pc, e.pc);
      end
    end
    if (if32.in_valid && if32.in_ready) q32.push_back(pend32);
    if (if64.in_valid && if64.in_ready) q64.push_back(pend64);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clr32 = 1'b0;
    clr64 = 1'b0;
    if32.in_valid = 1'b1;          // ignored while in reset
    if32.inscode  = 32'hFFF00093;
    if32.in_pc    = 32'h0;
    if32.out_ready = 1'b1;
    if64.in_valid = 1'b0;
    if64.inscode  = 32'h0;
    if64.in_pc    = 64'h0;
    if64.out_ready = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_in_ready32", 64'(if32.in_ready), 64'd0);
    chk("rst_in_ready64", 64'(if64.in_ready), 64'd0);
    chk("rst_out_valid32", 64'(if32.out_valid), 64'd0);
    chk("rst_fmt32", 64'(if32.out_fmt), 64'd7);
    chk("rst_imm32", {32'b0, if32.Immout}, 64'd0);
    chk("rst_pc32", {32'b0, if32.out_pc}, 64'd0);
    chk("rst_ill32", 64'(if32.out_illegal), 64'd0);
    chk("rst_cnt32", 64'(cnt32), 64'd0);
    chk("rst_fmt64", 64'(if64.out_fmt), 64'd7);
    chk("rst_cnt64", 64'(cnt64), 64'd0);
    if32.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready32", 64'(if32.in_ready), 64'd1);

    // Back-to-back decode, one result per cycle
    drive32(32'hFFF00093, 32'h100, 64'hFFFFFFFF, 3'd1, 1'b0);
    drive64(32'h800000B7, 64'h1000, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    step();
    chk("lat_valid32", 64'(if32.out_valid), 64'd1);
    chk("lat_valid64", 64'(if64.out_valid), 64'd1);
    drive32(32'hFE112E23, 32'h104, 64'hFFFFFFFC, 3'd2, 1'b0);
    drive64(32'h00000033, 64'h1004, 64'h0, 3'd0, 1'b0);
    step();
    chk("b2b_valid32_a", 64'(if32.out_valid), 64'd1);
    drive32(32'hFE000CE3, 32'h108, 64'hFFFFFFF8, 3'd3, 1'b0);
    if64.in_valid = 1'b0;
    step();
    chk("b2b_valid32_b", 64'(if32.out_valid), 64'd1);
    drive32(32'h123450B7, 32'h10C, 64'h12345000, 3'd4, 1'b0);
    step();
    chk("b2b_valid32_c", 64'(if32.out_valid), 64'd1);
    if32.in_valid = 1'b0;
    step();
    step();
    chk("b2b_drained32", 64'(q32.size()), 64'd0);
    chk("b2b_drained64", 64'(q64.size()), 64'd0);
    chk("b2b_idle32", 64'(if32.out_valid), 64'd0);

    // Back-pressure: A in output reg, B in skid, C held upstream
    if32.out_ready = 1'b0;
    drive32(32'h00500093, 32'h200, 64'h5, 3'd1, 1'b0);
    step();
    chk("bp_ready_after_a", 64'(if32.in_ready), 64'd1);
    drive32(32'h0080006F, 32'h204, 64'h8, 3'd5, 1'b0);
    step();
    chk("bp_ready_after_b", 64'(if32.in_ready), 64'd0);
    drive32(32'h00001097, 32'h208, 64'h1000, 3'd4, 1'b0);
    step();
    step();
    chk("bp_hold_imm", {32'b0, if32.Immout}, 64'h5);
    chk("bp_hold_pc", {32'b0, if32.out_pc}, 64'h200);
    chk("bp_queued", 64'(q32.size()), 64'd2);
    if32.out_ready = 1'b1;
    step();
    step();
    if32.in_valid = 1'b0;
    step();
    step();
    chk("bp_drained", 64'(q32.size()), 64'd0);
    chk("bp_idle", 64'(if32.out_valid), 64'd0);

    // Illegal opcode with saturating 2-bit counter
    for (int k = 0; k < 4; k++) begin
      drive32(32'h0000007F, 32'h300 + 32'(4 * k), 64'h0, 3'd7, 1'b1);
      step();
      chk("ill_cnt", 64'(cnt32), 64'(cnt_exp[k]));
    end
    if32.in_valid = 1'b0;
    step();
    clr32 = 1'b1;
    step();
    clr32 = 1'b0;
    chk("ill_cnt_clr", 64'(cnt32), 64'd0);
    chk("ill_drained", 64'(q32.size()), 64'd0);

    // Reset in the middle of a stall
    if32.out_ready = 1'b0;
    drive32(32'h00700093, 32'h400, 64'h7, 3'd1, 1'b0);
    step();
    drive32(32'h0000007F, 32'h404, 64'h0, 3'd7, 1'b1);
    step();
    chk("stall_in_ready", 64'(if32.in_ready), 64'd0);
    chk("stall_cnt", 64'(cnt32), 64'd1);
    if32.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 64'(if32.in_ready), 64'd0);
    step();
    q32.delete();
    q64.delete();
    rst = 1'b0;
    #1;
    chk("mrst_out_valid", 64'(if32.out_valid), 64'd0);
    chk("mrst_cnt", 64'(cnt32), 64'd0);
    chk("mrst_fmt", 64'(if32.out_fmt), 64'd7);
    chk("mrst_in_ready", 64'(if32.in_ready), 64'd1);
    if32.out_ready = 1'b1;
    drive32(32'hFFF00093, 32'h500, 64'hFFFFFFFF, 3'd1, 1'b0);
    step();
    chk("mrst_next_valid", 64'(if32.out_valid), 64'd1);
    if32.in_valid = 1'b0;
    step();
    step();
    chk("mrst_drained", 64'(q32.size()), 64'd0);
    chk("mrst_idle", 64'(if32.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
